program_loader: RTL and testbench

//  Drives the core's byte-wide program-load port (mem_en/mem_data/mem_addr) and its reset.

---
 rtl/program_loader.sv | 170 +++++++++++++++++
 tb/tb_program_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Purpose : streams a 32-bit program image into the core's byte-wide load port, then runs the core and
//           watches its a7/gp/a0 taps for the end-of-test convention (a7==93), reporting pass/fail/timeout.
// Latency : word accepted at edge N is written as bytes during cycles N+1..N+4; one word per 5 cycles.
// Backpr. : s_ready is high only in LOAD_WAIT; it stays low while bytes drain and after capacity/last.
// Ports   : clock/reset (sync, active-high); start pulse; s_valid/s_data/s_last/s_ready word stream;
//           core_reset, mem_en/mem_data/mem_addr drive the core; gp/a7/a0 are core register taps;
//           busy/done/pass/fail/timed_out/overflow/word_count report status (all registered).
module program_loader #(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 4096,
    parameter int TIMEOUT   = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             core_reset,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] gp,
    input  logic [WIDTH-1:0] a7,
    input  logic [WIDTH-1:0] a0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timed_out,
    output logic             overflow,
    output logic [WIDTH-1:0] word_count
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_WAIT = 4'd1;
    localparam logic [3:0] S_BYTE0     = 4'd2;
    localparam logic [3:0] S_BYTE1     = 4'd3;
    localparam logic [3:0] S_BYTE2     = 4'd4;
    localparam logic [3:0] S_BYTE3     = 4'd5;
    localparam logic [3:0] S_RELEASE   = 4'd6;
    localparam logic [3:0] S_RUN       = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam logic [WIDTH-1:0] CAPACITY = WIDTH'(MEM_DEPTH / 4);
    localparam logic [WIDTH-1:0] END_CODE = WIDTH'(93);
    localparam int               CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    CYC_LAST = CW'(TIMEOUT - 1);

    logic [3:0]       state;
    logic [WIDTH-1:0] word_q;
    logic             last_q;
    logic             armed;
    logic [CW-1:0]    cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            s_ready    <= 1'b0;
            core_reset <= 1'b1;
            mem_en     <= 1'b0;
            mem_data   <= '0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timed_out  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            armed      <= 1'b0;
            cycles     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD_WAIT;
                        s_ready    <= 1'b1;
                        core_reset <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        timed_out  <= 1'b0;
                        overflow   <= 1'b0;
                        word_count <= '0;
                        mem_addr   <= '0;
                    end
                end
                S_LOAD_WAIT: begin
                    if (s_valid) begin
                        word_q   <= s_data;
                        last_q   <= s_last;
                        s_ready  <= 1'b0;
                        mem_en   <= 1'b1;
                        mem_addr <= {word_count[WIDTH-3:0], 2'b00};
                        mem_data <= WIDTH'(s_data[7:0]);
                        state    <= S_BYTE0;
                    end
                end
                S_BYTE0: begin
                    mem_addr <= mem_addr + 1'b1;
                    mem_data <= WIDTH'(word_q[15:8]);
                    state    <= S_BYTE1;
                end
                S_BYTE1: begin
                    mem_addr <= mem_addr + 1'b1;
                    mem_data <= WIDTH'(word_q[23:16]);
                    state    <= S_BYTE2;
                end
                S_BYTE2: begin
                    mem_addr <= mem_addr + 1'b1;
                    mem_data <= WIDTH'(word_q[31:24]);
                    state    <= S_BYTE3;
                end
                S_BYTE3: begin
                    mem_en     <= 1'b0;
                    word_count <= word_count + 1'b1;
                    // A full memory ends the load; it is only an overflow if the host had more to send.
                    if (last_q || (word_count + 1'b1 == CAPACITY)) begin
                        overflow <= ~last_q;
                        state    <= S_RELEASE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= S_LOAD_WAIT;
                    end
                end
                S_RELEASE: begin
                    // core_reset is still high this cycle so the core restarts from pc 0.
                    core_reset <= 1'b0;
                    cycles     <= '0;
                    armed      <= 1'b0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    if ((a7 == END_CODE) && armed) begin
                        pass       <= (gp == WIDTH'(1)) && (a0 == '0);
                        fail       <= !((gp == WIDTH'(1)) && (a0 == '0));
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        state      <= S_DONE;
                    end else if (cycles == CYC_LAST) begin
                        timed_out  <= 1'b1;
                        fail       <= 1'b1;
                        pass       <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cycles <= cycles + 1'b1;
                        // Arm only once a7 has been seen different from the end code, so a stale
                        // 93 left over from a previous run is ignored. An unknown a7 takes the else.
                        if (a7 == END_CODE) begin
                            armed <= armed;
                        end else begin
                            armed <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Purpose : randomized self-checking bench for program_loader against a rule-level reference model.
// Latency : n/a (bench).
// Backpr. : drives s_valid continuously and waits on s_ready.
module tb_program_loader;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 50;
    localparam int CAP   = DEPTH / 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [W-1:0]  gp = '0;
    logic [W-1:0]  a7 = '0;
    logic [W-1:0]  a0 = '0;
    logic          s_ready, core_reset, mem_en, busy, done, pass, fail, timed_out, overflow;
    logic [W-1:0]  mem_data, mem_addr, word_count;

    always #5 clock = ~clock;

    program_loader #(.WIDTH(W), .MEM_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .core_reset(core_reset), .mem_en(mem_en), .mem_data(mem_data), .mem_addr(mem_addr),
        .gp(gp), .a7(a7), .a0(a0),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
        .overflow(overflow), .word_count(word_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampling mid-cycle.
    int          cyc = 0;
    int          acc_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          rel_cnt = 0;
    int          rdy_viol = 0;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (s_valid && s_ready) acc_q.push_back(cyc);
            if (mem_en) begin
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_data);
                if (s_ready) rdy_viol++;
            end
            if (busy && core_reset && !mem_en && !s_ready) rel_cnt++;
        end
    end

    logic [31:0] img [8];
    logic [31:0] sa7 [64];
    logic [31:0] sgp [64];
    logic [31:0] sa0 [64];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_wait", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_core(output int obs_end);
        int n = 0;
        int t = 0;
        obs_end = -1;
        while (!(busy && !core_reset) && n < 200) begin
            tick();
            n++;
        end
        chk("run_entry", busy && !core_reset, 1);
        while (t < 60) begin
            a7 = sa7[t];
            gp = sgp[t];
            a0 = sa0[t];
            tick();
            t++;
            if (done) begin
                obs_end = t - 1;
                break;
            end
        end
    endtask

    // mode 0: random register activity with a possible stale 93 prefix; mode 1: a7 stuck at 93.
    task automatic gen_seq(input int mode);
        int k;
        k = $urandom_range(0, 4);
        for (int t = 0; t < 64; t++) begin
            if (mode == 1 || t < k) sa7[t] = 32'd93;
            else sa7[t] = ($urandom_range(0, 2) == 0) ? 32'd93 : 32'($urandom_range(0, 92));
            sgp[t] = 32'($urandom_range(0, 1));
            sa0[t] = 32'($urandom_range(0, 1));
        end
    endtask

    task automatic do_test(input int n, input bit with_last);
        int exp_words, exp_end, obs_end, nw;
        bit armed, exp_to, exp_pass;
        acc_q.delete();
        wa_q.delete();
        wd_q.delete();
        rel_cnt  = 0;
        rdy_viol = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ready", s_ready, 1);
        chk("load_count", word_count, 0);
        chk("load_done", done, 0);
        chk("load_overflow", overflow, 0);
        chk("load_core_reset", core_reset, 1);
        chk("load_busy", busy, 1);

        for (int i = 0; i < n; i++) begin
            if (i < CAP) begin
                send_word(img[i], with_last && (i == n - 1));
                if (i == 0) begin
                    // start while busy must be ignored
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
            end else begin
                s_valid = 1'b1;
                s_data  = img[i];
                s_last  = 1'b0;
            end
        end
        run_core(obs_end);
        s_valid = 1'b0;

        // Reference: the image is written byte-by-byte, little-endian from address 0.
        exp_words = with_last ? n : CAP;
        armed = 1'b0;
        exp_end = -1;
        exp_to = 1'b0;
        exp_pass = 1'b0;
        for (int t = 0; t < TMO; t++) begin
            if (armed && sa7[t] == 32'd93) begin
                exp_end = t;
                exp_pass = (sgp[t] == 32'd1) && (sa0[t] == 32'd0);
                break;
            end
            if (t == TMO - 1) begin
                exp_end = t;
                exp_to = 1'b1;
                break;
            end
            if (sa7[t] != 32'd93) armed = 1'b1;
        end

        chk("end_cycle", obs_end, exp_end);
        chk("done", done, 1);
        chk("pass", pass, exp_pass);
        chk("fail", fail, !exp_pass);
        chk("timed_out", timed_out, exp_to);
        chk("busy_done", busy, 0);
        chk("core_reset_done", core_reset, 1);
        chk("word_count", word_count, exp_words);
        chk("overflow", overflow, !with_last);
        chk("accepts", acc_q.size(), exp_words);
        for (int i = 1; i < acc_q.size(); i++) chk("accept_gap", acc_q[i] - acc_q[i-1], 5);
        chk("write_count", wa_q.size(), 4 * exp_words);
        nw = (wa_q.size() < 4 * exp_words) ? wa_q.size() : 4 * exp_words;
        for (int j = 0; j < nw; j++) begin
            chk("write_addr", wa_q[j], j);
            chk("write_data", wd_q[j], (img[j/4] >> (8 * (j % 4))) & 32'hff);
        end
        chk("release_cycles", rel_cnt, 1);
        chk("ready_low_in_bytes", rdy_viol, 0);
        repeat (3) tick();
        chk("done_held", done, 1);
        chk("pass_held", pass, exp_pass);
    endtask

    initial begin
        int n;
        bit wl;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_word_count", word_count, 0);
        reset = 1'b0;
        tick();
        chk("idle_not_busy", busy, 0);

        // two-word image, clean pass
        img[0] = 32'h0000_0013;
        img[1] = 32'h1234_5678;
        for (int t = 0; t < 64; t++) begin
            sa7[t] = (t == 0) ? 32'd0 : 32'd93;
            sgp[t] = 32'd1;
            sa0[t] = 32'd0;
        end
        do_test(2, 1'b1);

        // armed end with bad result registers
        img[0] = $urandom;
        for (int t = 0; t < 64; t++) begin
            sa7[t] = (t == 0) ? 32'd7 : 32'd93;
            sgp[t] = 32'd5;
            sa0[t] = 32'd5;
        end
        do_test(1, 1'b1);

        // stale end code never cleared -> timeout
        for (int i = 0; i < 8; i++) img[i] = $urandom;
        gen_seq(1);
        do_test(3, 1'b1);

        // capacity reached without s_last
        for (int i = 0; i < 8; i++) img[i] = $urandom;
        gen_seq(0);
        do_test(5, 1'b0);

        // reset in the middle of a byte burst, then reload from scratch
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hdead_beef, 1'b0);
        tick();
        chk("byte1_en", mem_en, 1);
        chk("byte1_addr", mem_addr, 1);
        chk("byte1_data", mem_data, 32'hbe);
        reset = 1'b1;
        tick();
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_word_count", word_count, 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) img[i] = $urandom;
        gen_seq(0);
        do_test(3, 1'b1);

        // random images and run behaviour
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 8; i++) img[i] = $urandom;
            wl = ($urandom_range(0, 4) != 0);
            n = wl ? $urandom_range(1, CAP) : CAP + 1;
            gen_seq(($urandom_range(0, 5) == 0) ? 1 : 0);
            do_test(n, wl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
